// File: rtl/div16_by8_seq_pkg.sv
// Shared definitions for the sequential restoring divider.
package div16_by8_seq_pkg;

  localparam int unsigned NW_DEF = 16;
  localparam int unsigned DW_DEF = 8;
  localparam int unsigned CNT_W  = $clog2(NW_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div16_by8_seq_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract.
module div16_by8_seq_div_step #(
  parameter int unsigned DW = 8
) (
  input  logic [DW:0]   pr,
  input  logic          msb,
  input  logic [DW-1:0] divisor,
  output logic [DW:0]   pr_next,
  output logic          qbit
);

  logic [DW:0] shifted;
  logic [DW:0] dvs_ext;

  // Partial remainder is one bit wider than the divisor so the compare never truncates
  always_comb begin
    shifted = {pr[DW-1:0], msb};
    dvs_ext = {1'b0, divisor};
    pr_next = shifted;
    qbit    = 1'b0;
    if (shifted >= dvs_ext) begin
      pr_next = shifted - dvs_ext;
      qbit    = 1'b1;
    end
  end

endmodule

// File: rtl/div16_by8_seq.sv
// Sequential restoring divider, one quotient bit per clock, start/busy/done handshake.
module div16_by8_seq
  import div16_by8_seq_pkg::*;
#(
  parameter int unsigned NW = NW_DEF,
  parameter int unsigned DW = DW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [NW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          busy,
  output logic          done,
  output logic [NW-1:0] quotient,
  output logic [DW-1:0] remainder,
  output logic          ovf,
  output logic          dbz
);

  localparam int unsigned CW = $clog2(NW);

  state_t        state;
  logic [NW-1:0] dvd_sh;
  logic [DW-1:0] dvs;
  logic [DW:0]   pr;
  logic [NW-1:0] q_sh;
  logic [CW-1:0] cnt;

  logic [DW:0]   pr_next;
  logic          qbit;
  logic [NW-1:0] q_new;

  div16_by8_seq_div_step #(.DW(DW)) u_step (
    .pr      (pr),
    .msb     (dvd_sh[NW-1]),
    .divisor (dvs),
    .pr_next (pr_next),
    .qbit    (qbit)
  );

  // Quotient register with the freshly computed bit shifted into the LSB
  always_comb begin
    q_new = {q_sh[NW-2:0], qbit};
  end

  // Control FSM, iteration datapath and registered result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      dvd_sh    <= '0;
      dvs       <= '0;
      pr        <= '0;
      q_sh      <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      ovf       <= 1'b0;
      dbz       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy <= 1'b1;
            if (divisor == '0) begin
              quotient  <= '1;
              remainder <= '0;
              dbz       <= 1'b1;
              ovf       <= 1'b1;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              dvd_sh <= dividend;
              dvs    <= divisor;
              pr     <= '0;
              q_sh   <= '0;
              cnt    <= '0;
              state  <= RUN;
            end
          end
        end
        RUN: begin
          dvd_sh <= {dvd_sh[NW-2:0], 1'b0};
          pr     <= pr_next;
          q_sh   <= q_new;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(NW - 1)) begin
            quotient  <= q_new;
            remainder <= pr_next[DW-1:0];
            ovf       <= |q_new[NW-1:DW];
            dbz       <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/div16_by8_seq.md
Name: div16_by8_seq

Overview:
Sequential restoring divider that inverts the 8x8 array multiplier: it divides a 16-bit product-width dividend by an 8-bit divisor and returns quotient and remainder. It computes one quotient bit per clock and uses a start/busy/done handshake. It sits beside the multiplier in the arithmetic datapath, and checks that the quotient fits the multiplier's 8-bit operand width.

Parameters:
NW, 16, dividend and quotient width
DW, 8, divisor and remainder width

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only in IDLE
dividend  input  NW  numerator; captured on the accepted start
divisor  input  DW  denominator; captured on the accepted start
busy  output  1  high whenever state != IDLE
done  output  1  single-cycle pulse; results are valid while high and held afterwards
quotient  output  NW  dividend / divisor
remainder  output  DW  dividend % divisor
ovf  output  1  quotient[NW-1:DW] != 0, meaning the quotient does not fit a DW-bit multiplier operand
dbz  output  1  divide-by-zero flag

Behaviour:
- One clock. Reset is synchronous and active-high on rst, which overrides all other activity, including mid-operation.
- Reset values: state=IDLE, busy=0, done=0, quotient=0, remainder=0, ovf=0, dbz=0, internal iteration counter=0.
- States:
  - IDLE: waits for start.
  - RUN: performs iterations.
  - DONE: presents results for one cycle.
- IDLE, start=1, divisor!=0:
  - capture dividend into a shift register and divisor into a hold register
  - clear the partial remainder (DW+1 bits) and the counter
  - go to RUN
- IDLE, start=1, divisor==0:
  - go directly to DONE
  - at that edge: quotient={NW{1}}, remainder=0, dbz=1, ovf=1
- RUN, one iteration per edge:
  - pr' = {pr[DW-1:0], dividend_msb}; shift the dividend register left
  - if pr' >= divisor: pr' -= divisor, quotient bit = 1; else quotient bit = 0
  - the quotient bit shifts into the LSB of the quotient register
  - counter increments
- After NW iterations (counter == NW-1 at the edge), at that same edge:
  - write quotient, remainder=pr[DW-1:0], ovf, dbz=0
  - go to DONE
- DONE: done=1 for exactly one cycle, then unconditionally back to IDLE.
- Latency, with the start-sampling edge counted as edge 0:
  - normal case: done is high in the cycle after edge NW (16) and drops after edge NW+1
  - dbz case: done is high in the cycle after edge 0
- start while busy (RUN or DONE) is ignored, not queued. A new start is accepted in the first IDLE cycle after done.
- dividend and divisor are don't-care except on the accepting edge. Changing them mid-operation has no effect.
- quotient, remainder, ovf and dbz are updated only at completion. They hold their value through IDLE and during the next RUN until the next completion.
- Arithmetic:
  - unsigned
  - the partial remainder is DW+1 bits so the compare never truncates
  - the remainder is always < divisor
  - invariant: quotient*divisor + remainder == dividend (not checked when dbz)
- rst during RUN or DONE: go to IDLE at that edge with all outputs at reset values. No done pulse is produced for the aborted operation.

Decomposition:
- Shared package/header holds:
  - state encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2
  - NW/DW defaults
  - counter width = clog2(NW)
- One combinational sub-module is natural: div_step. Inputs are pr, the dividend MSB and the divisor; outputs are next pr and the quotient bit. The top module holds the FSM, the counter and the registers.

Test Plan:
- Reset then start with dividend=45000, divisor=200 -> done pulse at edge 16+1; quotient=225, remainder=0, ovf=0, dbz=0; busy high for 17 cycles.
- dividend=1000, divisor=7 -> quotient=142, remainder=6, ovf=0.
- dividend=16'hFFFF, divisor=1 -> quotient=65535, remainder=0, ovf=1.
- divisor=0, dividend=1234 -> done in the cycle after the start edge; dbz=1, quotient=16'hFFFF, remainder=0; busy high for one cycle.
- Pulse start again at edge 5 of a run, and assert rst at edge 10 of a second run:
  - the stray start is ignored and the first result is unaffected
  - rst gives outputs 0 and busy=0, with no done pulse
  - the next start is accepted normally
- Multiplier round-trip: for 2000 random a,b with b!=0, feed y=a*b from the 8x8 multiplier with divisor=b -> quotient==a, remainder==0, ovf==0. This set must include the corner a=255, b=255 (65025/255 -> 255).
